// File: rtl/dcache_controller.sv
// dcache_controller
//   Sequencing controller for a 2-way set-associative data cache
//   (16 sets, 256-bit lines, 25-bit tag entries {valid, dirty, tag[22:0]}).
//   Hits are served in the same cycle. On a miss the CPU is stalled, a dirty
//   victim is written back, the line is refilled from memory, and the access
//   replays as a hit.
// Ports
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   cpu_req_i/cpu_wr_i/cpu_addr_i/
//   cpu_data_i                        CPU request (held while cpu_stall_o=1)
//   cpu_data_o, cpu_stall_o           load data, stall
//   sram_enable_o/sram_write_o/
//   sram_addr_o/sram_tag_o/
//   sram_data_o                       cache SRAM control and write data
//   sram_tag_i/sram_data_i/sram_hit_i hit-way (or LRU-victim) tag and line, hit flag
//   mem_enable_o/mem_write_o/
//   mem_addr_o/mem_data_o             line request to memory (held until ack)
//   mem_data_i, mem_ack_i             fetched line, one-cycle completion pulse
module dcache_controller #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  output logic [3:0]        sram_addr_o,
  output logic [24:0]       sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  input  logic [24:0]       sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i,
  input  logic              sram_hit_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int WORDS = LINE_W / WORD_W;

  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, FILL} state_t;

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   line_q;      // refilled line waiting to be written in FILL
  logic [LINE_W-1:0]   mem_data_q;  // victim line buffer, driven to memory
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_en_q;
  logic                mem_wr_q;

  logic [3:0]          index;
  logic [22:0]         cpu_tag;
  logic [2:0]          wsel;
  logic                idle;
  logic                req_hit, load_hit, store_hit, miss_req;
  logic                victim_dirty;
  logic [WORD_W-1:0]   line_words [WORDS];
  logic [LINE_W-1:0]   store_line;

  assign index   = cpu_addr_i[8:5];
  assign cpu_tag = cpu_addr_i[31:9];
  assign wsel    = cpu_addr_i[4:2];
  assign idle    = (state_q == IDLE);

  // Hit handling is combinational; reset is folded in so nothing is written
  // and no stall is raised while reset is held.
  assign req_hit   = idle & cpu_req_i & sram_hit_i & ~rst_i;
  assign load_hit  = req_hit & ~cpu_wr_i;
  assign store_hit = req_hit & cpu_wr_i;
  assign miss_req  = idle & cpu_req_i & ~sram_hit_i & ~rst_i;

  assign victim_dirty = sram_tag_i[24] & sram_tag_i[23];

  // Split the SRAM line into words and build the store-merged line.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    assign line_words[gi] = sram_data_i[gi*WORD_W +: WORD_W];
    assign store_line[gi*WORD_W +: WORD_W] =
      (wsel == 3'(gi)) ? cpu_data_i : sram_data_i[gi*WORD_W +: WORD_W];
  end

  assign cpu_data_o    = load_hit ? line_words[wsel] : '0;
  assign cpu_stall_o   = ~idle | miss_req;
  assign sram_enable_o = cpu_req_i | ~idle;
  assign sram_addr_o   = index;
  assign sram_write_o  = store_hit | (state_q == FILL);
  // Dirty bit is set only by a store hit; a fill always installs a clean line.
  assign sram_tag_o    = {1'b1, store_hit, cpu_tag};
  assign sram_data_o   = store_hit ? store_line :
                         (state_q == FILL) ? line_q : '0;

  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_wr_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (miss_req) state_d = MISS;
      MISS:      state_d = victim_dirty ? WRITEBACK : REFILL;
      WRITEBACK: if (mem_ack_i) state_d = REFILL;
      REFILL:    if (mem_ack_i) state_d = FILL;
      FILL:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      line_q     <= '0;
      mem_data_q <= '0;
      mem_addr_q <= '0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        MISS: begin
          // The SRAM presents the LRU victim this cycle; latch it and
          // launch either the write-back or the fetch.
          mem_en_q <= 1'b1;
          if (victim_dirty) begin
            mem_wr_q   <= 1'b1;
            mem_addr_q <= {sram_tag_i[22:0], index, 5'b0};
            mem_data_q <= sram_data_i;
          end else begin
            mem_wr_q   <= 1'b0;
            mem_addr_q <= {cpu_tag, index, 5'b0};
          end
        end
        WRITEBACK: begin
          // Request stays up across the ack and turns into the fetch.
          if (mem_ack_i) begin
            mem_wr_q   <= 1'b0;
            mem_addr_q <= {cpu_tag, index, 5'b0};
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            line_q   <= mem_data_i;
            mem_en_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Testbench for dcache_controller: behavioural 2-way LRU SRAM and a memory
// responder with programmable ack latency; directed CPU accesses.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         cpu_req_i = 1'b0;
  logic         cpu_wr_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_wr_i(cpu_wr_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  // ---------------- SRAM model: 2 ways x 16 sets, one LRU bit per set ----
  logic [24:0]  tag_arr  [2][16];
  logic [255:0] data_arr [2][16];
  logic         lru_arr  [16];
  logic         sram_clr = 1'b1;
  int           sram_wr_cnt = 0;
  logic [3:0]   s_idx;
  logic         s_hit0, s_hit1, s_way;

  always_comb begin
    s_idx  = sram_addr_o;
    s_hit0 = tag_arr[0][s_idx][24] && (tag_arr[0][s_idx][22:0] == sram_tag_o[22:0]);
    s_hit1 = tag_arr[1][s_idx][24] && (tag_arr[1][s_idx][22:0] == sram_tag_o[22:0]);
    s_way  = s_hit0 ? 1'b0 : (s_hit1 ? 1'b1 : lru_arr[s_idx]);
    sram_hit_i  = sram_enable_o && (s_hit0 || s_hit1);
    sram_tag_i  = tag_arr[s_way][s_idx];
    sram_data_i = data_arr[s_way][s_idx];
  end

  always @(posedge clk_i) begin
    if (sram_clr) begin
      for (int s = 0; s < 16; s++) begin
        tag_arr[0][s]  <= '0;
        tag_arr[1][s]  <= '0;
        data_arr[0][s] <= '0;
        data_arr[1][s] <= '0;
        lru_arr[s]     <= 1'b0;
      end
    end else if (sram_enable_o) begin
      if (sram_write_o) begin
        tag_arr[s_way][s_idx]  <= sram_tag_o;
        data_arr[s_way][s_idx] <= sram_data_o;
        lru_arr[s_idx]         <= ~s_way;
        sram_wr_cnt            <= sram_wr_cnt + 1;
      end else if (sram_hit_i) begin
        lru_arr[s_idx] <= ~s_way;
      end
    end
  end

  // ---------------- Memory model and responder ---------------------------
  logic [255:0] mem_model [logic [31:0]];
  int           ack_delay = 3;
  int           req_cycles = 0;
  int           last_req_cycles = 0;
  int           unstable_cnt = 0;
  logic [31:0]  req_addr = '0;
  logic         req_wr = 1'b0;
  logic         log_wr [$];
  logic [31:0]  log_addr [$];
  logic [255:0] last_wb_line = '0;

  function automatic logic [255:0] line_pat(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = {a[15:0] ^ 16'h5A5A, 12'h000, 4'(w)};
    if (a == 32'h40) l[31:0] = 32'h1111_1111;
    return l;
  endfunction

  function automatic logic [255:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return line_pat(a);
  endfunction

  always @(negedge clk_i) begin
    if (mem_ack_i) mem_ack_i = 1'b0;
    if (!mem_enable_o) begin
      req_cycles = 0;
    end else begin
      if (req_cycles == 0) begin
        req_addr = mem_addr_o;
        req_wr   = mem_write_o;
      end else if (mem_addr_o !== req_addr || mem_write_o !== req_wr) begin
        unstable_cnt++;
      end
      req_cycles++;
      if (req_cycles == ack_delay) begin
        mem_ack_i = 1'b1;
        if (mem_write_o) begin
          mem_model[mem_addr_o] = mem_data_o;
          last_wb_line = mem_data_o;
        end else begin
          mem_data_i = mem_read(mem_addr_o);
        end
        log_wr.push_back(mem_write_o);
        log_addr.push_back(mem_addr_o);
        last_req_cycles = req_cycles;
        req_cycles = 0;
      end
    end
  end

  // ---------------- Checking and stimulus -------------------------------
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            output int stalls, output logic [31:0] rdata, output logic sw,
                            output logic [24:0] st, output logic [255:0] sd);
    @(negedge clk_i);
    cpu_req_i  = 1'b1;
    cpu_wr_i   = wr;
    cpu_addr_i = a;
    cpu_data_i = d;
    stalls = 0;
    #1;
    while (cpu_stall_o && stalls < 100) begin
      stalls++;
      @(negedge clk_i);
      #1;
    end
    if (stalls >= 100) check_val("stall_timeout", 64'(stalls), 64'd0);
    rdata = cpu_data_o;
    sw    = sram_write_o;
    st    = sram_tag_o;
    sd    = sram_data_o;
    @(posedge clk_i);
    #1;
    cpu_req_i = 1'b0;
    cpu_wr_i  = 1'b0;
    $display("[TB] %s addr=0x%08h data=0x%08h stalls=%0d", wr ? "ST" : "LD", a,
             wr ? d : rdata, stalls);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int           stalls;
    int           base;
    int           ucnt;
    int           wcnt;
    int           n;
    logic [31:0]  rdata;
    logic         sw;
    logic [24:0]  st;
    logic [255:0] sd;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_stall", cpu_stall_o, 0);
    check_val("rst_mem_en", mem_enable_o, 0);
    check_val("rst_mem_wr", mem_write_o, 0);
    check_val("rst_mem_addr", mem_addr_o, 0);
    check_val("rst_mem_data", mem_data_o[63:0], 0);
    check_val("rst_sram_wr", sram_write_o, 0);
    check_val("rst_sram_en", sram_enable_o, 0);
    check_val("rst_cpu_data", cpu_data_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    sram_clr = 1'b0;

    // Cold load 0x40, ack on 3rd request cycle
    ack_delay = 3;
    base = log_wr.size();
    cpu_access(1'b0, 32'h40, 32'h0, stalls, rdata, sw, st, sd);
    check_val("cold_stalls", 64'(stalls), 6);
    check_val("cold_data", rdata, 32'h1111_1111);
    check_val("cold_nreq", 64'(log_wr.size() - base), 1);
    check_val("cold_req_wr", log_wr[base], 0);
    check_val("cold_req_addr", log_addr[base], 32'h40);

    // Store hit 0x44
    cpu_access(1'b1, 32'h44, 32'hDEAD_BEEF, stalls, rdata, sw, st, sd);
    check_val("st_stalls", 64'(stalls), 0);
    check_val("st_sram_wr", sw, 1);
    check_val("st_tag", st, 25'h180_0000);
    check_val("st_word1", sd[63:32], 32'hDEAD_BEEF);
    check_val("st_word0", sd[31:0], 32'h1111_1111);
    cpu_access(1'b0, 32'h44, 32'h0, stalls, rdata, sw, st, sd);
    check_val("reload_stalls", 64'(stalls), 0);
    check_val("reload_data", rdata, 32'hDEAD_BEEF);

    // Fill 0x240 into the other way (victim invalid -> read only)
    base = log_wr.size();
    cpu_access(1'b0, 32'h240, 32'h0, stalls, rdata, sw, st, sd);
    check_val("f240_data", rdata, line_pat(32'h240) & 256'hFFFF_FFFF);
    check_val("f240_nreq", 64'(log_wr.size() - base), 1);
    check_val("f240_wr", log_wr[base], 0);

    // Dirty eviction: 0x440 evicts dirty 0x040
    base = log_wr.size();
    cpu_access(1'b0, 32'h440, 32'h0, stalls, rdata, sw, st, sd);
    check_val("dirty_stalls", 64'(stalls), 9);
    check_val("dirty_nreq", 64'(log_wr.size() - base), 2);
    check_val("dirty_wr0", log_wr[base], 1);
    check_val("dirty_addr0", log_addr[base], 32'h40);
    check_val("dirty_wr1", log_wr[base+1], 0);
    check_val("dirty_addr1", log_addr[base+1], 32'h440);
    check_val("dirty_wb_word1", last_wb_line[63:32], 32'hDEAD_BEEF);
    check_val("dirty_data", rdata, line_pat(32'h440) & 256'hFFFF_FFFF);

    // Clean eviction in set 0
    cpu_access(1'b0, 32'h000, 32'h0, stalls, rdata, sw, st, sd);
    check_val("c000_data", rdata, 32'h5A5A_0000);
    cpu_access(1'b0, 32'h200, 32'h0, stalls, rdata, sw, st, sd);
    check_val("c200_data", rdata, 32'h585A_0000);
    base = log_wr.size();
    cpu_access(1'b0, 32'h400, 32'h0, stalls, rdata, sw, st, sd);
    check_val("c400_nreq", 64'(log_wr.size() - base), 1);
    check_val("c400_wr", log_wr[base], 0);
    check_val("c400_addr", log_addr[base], 32'h400);
    check_val("c400_data", rdata, 32'h5E5A_0000);

    // Slow memory: ack after 10 request cycles
    ack_delay = 10;
    ucnt = unstable_cnt;
    cpu_access(1'b0, 32'h604, 32'h0, stalls, rdata, sw, st, sd);
    check_val("slow_stalls", 64'(stalls), 13);
    check_val("slow_req_cycles", 64'(last_req_cycles), 10);
    check_val("slow_stable", 64'(unstable_cnt - ucnt), 0);
    check_val("slow_data", rdata, 32'h5C5A_0001);

    // Prepare set 2: dirty 0x440 becomes LRU
    ack_delay = 3;
    cpu_access(1'b1, 32'h448, 32'hCAFE_F00D, stalls, rdata, sw, st, sd);
    check_val("prep_st_stalls", 64'(stalls), 0);
    cpu_access(1'b0, 32'h240, 32'h0, stalls, rdata, sw, st, sd);
    check_val("prep_ld_stalls", 64'(stalls), 0);

    // Reset in the middle of a write-back
    ack_delay = 5;
    @(negedge clk_i);
    cpu_req_i  = 1'b1;
    cpu_wr_i   = 1'b0;
    cpu_addr_i = 32'h640;
    n = 0;
    while (!(mem_enable_o && mem_write_o) && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check_val("rst_wb_reached", mem_enable_o & mem_write_o, 1);
    @(negedge clk_i);
    wcnt = sram_wr_cnt;
    #2;
    rst_i = 1'b1;
    #1;
    check_val("rst_mid_mem_en", mem_enable_o, 0);
    check_val("rst_mid_stall", cpu_stall_o, 0);
    check_val("rst_mid_mem_wr", mem_write_o, 0);
    check_val("rst_mid_sram_wr", sram_write_o, 0);
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk_i);
    #1;
    check_val("rst_after_sram_wrs", 64'(sram_wr_cnt - wcnt), 0);
    check_val("rst_after_mem_en", mem_enable_o, 0);
    check_val("rst_after_stall", cpu_stall_o, 0);
    $display("[TB] RST mid-writeback addr=0x00000640");

    // Replay: the dirty victim must still be there
    ack_delay = 3;
    base = log_wr.size();
    cpu_access(1'b0, 32'h640, 32'h0, stalls, rdata, sw, st, sd);
    check_val("replay_nreq", 64'(log_wr.size() - base), 2);
    check_val("replay_wr0", log_wr[base], 1);
    check_val("replay_addr0", log_addr[base], 32'h440);
    check_val("replay_wb_word2", last_wb_line[95:64], 32'hCAFE_F00D);
    check_val("replay_addr1", log_addr[base+1], 32'h640);
    check_val("replay_data", rdata, 32'h5C1A_0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
